// File: rtl/fft_stage_seq.sv
// fft_stage_seq: address sequencer for an in-place radix-2 FFT.
//
// Walks every butterfly of a SIZE-point transform, pass by pass. It issues one
// butterfly at a time to an external butterfly unit and waits for that unit to
// report write-back before it issues the next one.
//
// Loop nest per run:
//   pass p     = 1..LOG2SIZE
//   group g    = 0..2^(p-1)-1
//   twiddle k  = 0..span-1, where span = SIZE >> p
//   n = g*2*span + k (upper operand address), counter = k
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous, active-high reset
//   start     in   1   begin a run; only looked at while idle
//   bf_done   in   1   butterfly write-back pulse; only looked at while waiting
//   n         out  32  upper operand address of the current butterfly
//   p         out  32  current pass, 1..LOG2SIZE
//   counter   out  32  twiddle index k within the current group
//   bf_start  out  1   one-cycle pulse: n/p/counter valid, butterfly may begin
//   busy      out  1   run in progress
//   done      out  1   one-cycle pulse after the final butterfly
//   bf_count  out  32  butterflies completed in the current run
//
// Every output comes straight from a flop. Next values are computed from the
// next state, so no input reaches an output without passing through a register.
module fft_stage_seq #(
  parameter int unsigned SIZE     = 64,
  parameter int unsigned LOG2SIZE = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        bf_done,
  output logic [31:0] n,
  output logic [31:0] p,
  output logic [31:0] counter,
  output logic        bf_start,
  output logic        busy,
  output logic        done,
  output logic [31:0] bf_count
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] p_q, p_d;
  logic [31:0] counter_q, counter_d;
  logic [31:0] g_q, g_d;
  logic [31:0] bf_count_q, bf_count_d;
  logic        bf_start_q, bf_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Loop bounds for the current pass.
  logic [31:0] span;
  logic [31:0] span_m1;
  logic [31:0] groups_m1;
  logic        last_k;
  logic        last_g;
  logic        last_pass;
  logic        final_bf;

  always_comb begin
    span      = 32'(SIZE) >> p_q;
    span_m1   = span - 32'd1;
    groups_m1 = (32'd1 << (p_q - 32'd1)) - 32'd1;
    last_k    = (counter_q == span_m1);
    last_g    = (g_q == groups_m1);
    last_pass = (p_q == 32'(LOG2SIZE));
    final_bf  = last_k && last_g && last_pass;
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    p_d        = p_q;
    counter_d  = counter_q;
    g_d        = g_q;
    bf_count_d = bf_count_q;
    bf_start_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StIssue;
          n_d        = 32'd0;
          p_d        = 32'd1;
          counter_d  = 32'd0;
          g_d        = 32'd0;
          bf_count_d = 32'd0;
          bf_start_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      StIssue: begin
        // bf_done is deliberately ignored here; the butterfly has not started.
        state_d = StWait;
        busy_d  = 1'b1;
      end

      StWait: begin
        busy_d = 1'b1;
        if (bf_done) begin
          bf_count_d = bf_count_q + 32'd1;
          if (final_bf) begin
            // Indices stay on the final butterfly for observation.
            state_d = StFinish;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = StIssue;
            bf_start_d = 1'b1;
            if (!last_k) begin
              counter_d = counter_q + 32'd1;
              n_d       = n_q + 32'd1;
            end else if (!last_g) begin
              // At the end of a group n = g*2*span + span-1, so the next
              // group base (g+1)*2*span is n + span + 1.
              counter_d = 32'd0;
              g_d       = g_q + 32'd1;
              n_d       = n_q + span + 32'd1;
            end else begin
              counter_d = 32'd0;
              g_d       = 32'd0;
              n_d       = 32'd0;
              p_d       = p_q + 32'd1;
            end
          end
        end
      end

      StFinish: begin
        // start is not captured in this cycle; the sequencer is not idle yet.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= 32'd0;
      p_q        <= 32'd0;
      counter_q  <= 32'd0;
      g_q        <= 32'd0;
      bf_count_q <= 32'd0;
      bf_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      p_q        <= p_d;
      counter_q  <= counter_d;
      g_q        <= g_d;
      bf_count_q <= bf_count_d;
      bf_start_q <= bf_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign n        = n_q;
  assign p        = p_q;
  assign counter  = counter_q;
  assign bf_start = bf_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bf_count = bf_count_q;

endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed bench for fft_stage_seq at SIZE=64, LOG2SIZE=6.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fft_stage_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        bf_done;
  logic [31:0] n;
  logic [31:0] p;
  logic [31:0] counter;
  logic        bf_start;
  logic        busy;
  logic        done;
  logic [31:0] bf_count;

  int n_vec;
  int n_err;
  int completed;

  fft_stage_seq #(
    .SIZE    (64),
    .LOG2SIZE(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bf_done (bf_done),
    .n       (n),
    .p       (p),
    .counter (counter),
    .bf_start(bf_start),
    .busy    (busy),
    .done    (done),
    .bf_count(bf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse bf_done for one cycle; returns on the cycle after it was sampled.
  task automatic pulse_done();
    bf_done = 1'b1;
    tick();
    bf_done = 1'b0;
    completed++;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    completed = 0;
    rst       = 1'b1;
    start     = 1'b0;
    bf_done   = 1'b0;
    repeat (2) tick();

    chk("rst_n", n, 32'd0);
    chk("rst_p", p, 32'd0);
    chk("rst_counter", counter, 32'd0);
    chk("rst_bf_start", bf_start, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_bf_count", bf_count, 32'd0);

    rst = 1'b0;
    tick();
    chk("idle_hold_busy", busy, 32'd0);

    // Run 1: first issue.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_bf_start", bf_start, 32'd1);
    chk("first_n", n, 32'd0);
    chk("first_p", p, 32'd1);
    chk("first_counter", counter, 32'd0);
    chk("first_busy", busy, 32'd1);

    // bf_done during ISSUE must be ignored.
    bf_done = 1'b1;
    tick();
    bf_done = 1'b0;
    chk("issue_done_ignored_count", bf_count, 32'd0);
    chk("wait_bf_start_low", bf_start, 32'd0);
    chk("wait_busy", busy, 32'd1);
    chk("wait_n_stable", n, 32'd0);

    // bf_done five cycles after bf_start.
    repeat (4) tick();
    chk("wait_still_no_issue", bf_start, 32'd0);
    pulse_done();
    chk("second_bf_start", bf_start, 32'd1);
    chk("second_n", n, 32'd1);
    chk("second_p", p, 32'd1);
    chk("second_counter", counter, 32'd1);
    chk("second_bf_count", bf_count, 32'd1);

    // start mid-run must be ignored.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrun_start_n", n, 32'd1);
    chk("midrun_start_p", p, 32'd1);
    chk("midrun_start_counter", counter, 32'd1);
    chk("midrun_start_bf_start", bf_start, 32'd0);
    chk("midrun_start_count", bf_count, 32'd1);

    // Butterflies 2..191 completed; each iteration lands on the next issue.
    while (completed < 191) begin
      pulse_done();
      if (completed == 31) begin
        chk("p1_last_n", n, 32'd31);
        chk("p1_last_counter", counter, 32'd31);
        chk("p1_last_p", p, 32'd1);
      end
      if (completed == 32) begin
        chk("p2_first_p", p, 32'd2);
        chk("p2_first_n", n, 32'd0);
        chk("p2_first_counter", counter, 32'd0);
      end
      if (completed == 48) begin
        chk("p2_g1_n", n, 32'd32);
        chk("p2_g1_counter", counter, 32'd0);
      end
      if (completed == 63) begin
        chk("p2_last_n", n, 32'd47);
        chk("p2_last_counter", counter, 32'd15);
        chk("p2_last_p", p, 32'd2);
      end
      if (completed >= 160) begin
        chk("p6_p", p, 32'd6);
        chk("p6_n", n, 32'(2 * (completed - 160)));
        chk("p6_counter", counter, 32'd0);
        chk("p6_bf_start", bf_start, 32'd1);
      end
      tick();
    end

    // Final butterfly.
    pulse_done();
    chk("fin_done", done, 32'd1);
    chk("fin_busy", busy, 32'd0);
    chk("fin_bf_count", bf_count, 32'd192);
    chk("fin_n", n, 32'd62);
    chk("fin_p", p, 32'd6);
    chk("fin_counter", counter, 32'd0);
    chk("fin_bf_start", bf_start, 32'd0);

    // start in FINISH must not be captured.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_done_low", done, 32'd0);
    chk("idle_busy_low", busy, 32'd0);
    chk("finish_start_ignored", bf_start, 32'd0);
    chk("idle_hold_n", n, 32'd62);
    tick();
    chk("idle_stays_idle", busy, 32'd0);
    chk("idle_no_issue", bf_start, 32'd0);
    chk("idle_hold_count", bf_count, 32'd192);

    // Run 2: reset while waiting in pass 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) begin
      bf_done = 1'b1;
      tick();
      bf_done = 1'b0;
      tick();
    end
    chk("run2_p3", p, 32'd3);
    chk("run2_busy", busy, 32'd1);
    chk("run2_count", bf_count, 32'd64);
    rst     = 1'b1;
    bf_done = 1'b1;
    start   = 1'b1;
    tick();
    rst     = 1'b0;
    bf_done = 1'b0;
    start   = 1'b0;
    chk("mrst_n", n, 32'd0);
    chk("mrst_p", p, 32'd0);
    chk("mrst_counter", counter, 32'd0);
    chk("mrst_bf_start", bf_start, 32'd0);
    chk("mrst_busy", busy, 32'd0);
    chk("mrst_done", done, 32'd0);
    chk("mrst_bf_count", bf_count, 32'd0);
    tick();
    chk("mrst_no_done_later", done, 32'd0);
    chk("mrst_still_idle", busy, 32'd0);

    // Run 3: restart from the beginning.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run3_bf_start", bf_start, 32'd1);
    chk("run3_n", n, 32'd0);
    chk("run3_p", p, 32'd1);
    chk("run3_busy", busy, 32'd1);
    chk("run3_count", bf_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_stage_seq.md
FFT_STAGE_SEQ -- requirements
Module: fft_stage_seq

Interface
REQ-001 Parameter SIZE, default 64, meaning FFT length in points (power of two, 4..1024).
REQ-002 Parameter LOG2SIZE, default 6, meaning log2(SIZE), the number of passes.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request a full FFT run; sampled only in IDLE.
REQ-006 bf_done  input  1  one-cycle pulse from the butterfly stage: current butterfly written back to RAM.
REQ-007 n  output  32  index of the butterfly's upper operand (butterfly N1 address).
REQ-008 p  output  32  pass number, 1..LOG2SIZE.
REQ-009 counter  output  32  twiddle index k within the current group.
REQ-010 bf_start  output  1  one-cycle pulse: n/p/counter valid, butterfly may begin.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  one-cycle pulse on completion of the final butterfly.
REQ-013 bf_count  output  32  number of butterflies completed in the current run.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and FINISH.
REQ-015 In IDLE with start=1, the next state SHALL be ISSUE with n=0, p=1, counter=0, bf_count=0.
REQ-016 In IDLE with start=0, the FSM SHALL remain in IDLE and all outputs SHALL hold their values.
REQ-017 ISSUE SHALL last exactly one cycle: bf_start=1 and busy=1, and the next state is WAIT.
REQ-018 In WAIT, busy SHALL be 1 and bf_start SHALL be 0; with bf_done=0 the FSM stays in WAIT.
REQ-019 n, p and counter SHALL be stable from the ISSUE cycle through the WAIT cycle in which bf_done=1.
REQ-020 Index rules: span = SIZE>>p; group g = 0..2^(p-1)-1 is the outer loop; k = 0..span-1 is the inner loop; n = g*2*span + k; counter = k.
REQ-021 In WAIT with bf_done=1 and not the final butterfly, the FSM SHALL advance in one cycle and go to ISSUE, so the next bf_start is the cycle after bf_done. Advance rules:
- k<span-1: k+1.
- k=span-1 and g<2^(p-1)-1: k=0, g+1.
- otherwise: k=0, g=0, p+1.
REQ-022 bf_count SHALL increment by 1 on every accepted bf_done and SHALL saturate at neither 0 nor wrap within a run.
REQ-023 The final butterfly is p=LOG2SIZE, n=SIZE-2, counter=0; its bf_done SHALL move the FSM to FINISH with n/p/counter unchanged.
REQ-024 FINISH SHALL last one cycle with done=1 and busy=0, then return to IDLE; done is 0 in all other states.
REQ-025 The total butterflies per run SHALL be (SIZE/2)*LOG2SIZE (192 for SIZE=64).
REQ-026 start outside IDLE SHALL be ignored; start in the FINISH cycle SHALL NOT be captured.
REQ-027 bf_done outside WAIT, including in the ISSUE cycle, SHALL be ignored.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 rst=1 SHALL, at the next clock edge, force IDLE with n=0, p=0, counter=0, bf_start=0, busy=0, done=0, bf_count=0.
REQ-030 rst SHALL override start and bf_done in the same cycle; reset mid-run SHALL abandon the run with no done pulse.

Verification
REQ-031 Starting a run means start=1 for one cycle in IDLE. Checks:
- bf_start the next cycle with n=0, p=1, counter=0, busy=1.
- bf_done 5 cycles later -> bf_start the next cycle with n=1, p=1, counter=1.
REQ-032 Pass 1 of SIZE=64: the 32nd butterfly is n=31, counter=31; the next butterfly is p=2, n=0, counter=0.
REQ-033 Pass 2, 17th butterfly: n=32, counter=0 (group 1); the pass ends at n=47, counter=15.
REQ-034 Pass 6 SHALL issue n=0,2,4,...,62 with counter=0 throughout. Completion checks:
- After the 192nd bf_done: done=1 for one cycle, busy=0, bf_count=192.
- The FSM is in IDLE the cycle after done.
REQ-035 Protocol violations SHALL be rejected:
- bf_done pulsed during an ISSUE cycle: the count does not change.
- start pulsed mid-run: no restart, n/p/counter unchanged.
REQ-036 Reset mid-run: rst during WAIT at p=3 -> all outputs 0 next cycle, no done pulse. A subsequent start SHALL begin again at n=0, p=1.
